// File: rtl/keypad_debounce.sv
// keypad_debounce
// Front end of the keypad path: synchronises the 12 raw key lines, rejects
// multi-key chords, debounces press and release, and reports the accepted key
// as a one-hot code, a binary index and a one-cycle key_valid pulse. With a
// non-zero REPEAT_CYCLES, key_valid re-pulses periodically while the key stays
// held.

module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,  // stable cycles to accept press/release
  parameter int REPEAT_CYCLES   = 0,   // held cycles between repeats, 0 = off
  parameter int CNT_W           = 16   // width of debounce and repeat counters
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic [11:0] keypad_in,  // raw key lines, 1 = pressed
  output logic [11:0] key_code,   // one-hot, sticky after release
  output logic [3:0]  key_idx,    // binary index of key_code
  output logic        key_valid,  // one-cycle pulse per press or repeat
  output logic        key_held    // high while accepted key is held
);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

  // Synchroniser stages and the single-key candidate derived from them.
  logic [11:0] sync_meta;
  logic [11:0] sync_key;
  logic [11:0] cand;

  // FSM state and its datapath registers.
  state_t           state,     state_n;
  logic [11:0]      lat,       lat_n;
  logic [CNT_W-1:0] cnt,       cnt_n;
  logic [CNT_W-1:0] rcnt,      rcnt_n;
  logic [11:0]      code_n;
  logic [3:0]       idx_n;
  logic             valid_n;
  logic             held_n;

  // Binary position of the set bit in a one-hot key vector.
  function automatic logic [3:0] enc(input logic [11:0] onehot);
    enc = '0;
    for (int i = 0; i < 12; i++) begin
      if (onehot[i]) enc = 4'(i);
    end
  endfunction

  // Two-flop synchroniser on the asynchronous key lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_key  <= '0;
    end else begin
      // NOTE: non-blocking assignments let both stages sample the values from
      // before the edge; blocking ones would collapse the chain to one flop.
      sync_meta <= keypad_in;
      sync_key  <= sync_meta;
    end
  end

  // Candidate key: the synchronised vector if exactly one line is active,
  // otherwise "no key" (idle lines and chords look the same downstream).
  always_comb begin
    cand = '0;
    if ((sync_key != '0) && ((sync_key & (sync_key - 12'd1)) == '0)) begin
      cand = sync_key;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat       <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= '0;
      key_idx   <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      lat       <= lat_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      key_code  <= code_n;
      key_idx   <= idx_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  // Next-state and next-output logic for the debounce FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned; a missing default here would infer a latch.
    state_n = state;
    lat_n   = lat;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    code_n  = key_code;
    idx_n   = key_idx;
    valid_n = 1'b0;
    held_n  = key_held;

    unique case (state)
      IDLE: begin
        if (cand != '0) begin
          state_n = DB_PRESS;
          lat_n   = cand;
          cnt_n   = '0;
        end
      end

      DB_PRESS: begin
        if (cand != lat) begin
          // Bounce or chord during the press window: abandon quietly.
          state_n = IDLE;
        end else if (cnt == DB_LAST) begin
          state_n = PRESSED;
          code_n  = lat;
          idx_n   = enc(lat);
          valid_n = 1'b1;
          held_n  = 1'b1;
          rcnt_n  = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      PRESSED: begin
        if (cand != lat) begin
          state_n = DB_RELEASE;
          cnt_n   = '0;
        end else if (REPEAT_EN) begin
          // Repeat counter reloads at its terminal count instead of wrapping.
          if (rcnt == RP_LAST) begin
            valid_n = 1'b1;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rcnt + CNT_ONE;
          end
        end
      end

      DB_RELEASE: begin
        if (cand == lat) begin
          // Short drop-out: resume the held key without a new pulse; the
          // repeat counter keeps its value.
          state_n = PRESSED;
        end else if (cnt == DB_LAST) begin
          state_n = IDLE;
          held_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce
// Two instances share the key lines and reset: one without auto-repeat and one
// with a 10-cycle repeat. A cycle-level reference model, written in terms of
// "pending key age" and "consecutive mismatch count", predicts both instances
// on every clock; directed tables and sequences cover the corner cases.

module tb_keypad_debounce;

  localparam int D  = 4;
  localparam int R1 = 10;

  logic        clk;
  logic        rst;
  logic [11:0] keypad_in;
  logic [11:0] code0, code1;
  logic [3:0]  idx0, idx1;
  logic        valid0, valid1;
  logic        held0, held1;

  keypad_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .keypad_in (keypad_in),
    .key_code  (code0),
    .key_idx   (idx0),
    .key_valid (valid0),
    .key_held  (held0)
  );

  keypad_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R1), .CNT_W(16)) dut_rep (
    .clk       (clk),
    .rst       (rst),
    .keypad_in (keypad_in),
    .key_code  (code1),
    .key_idx   (idx1),
    .key_valid (valid1),
    .key_held  (held1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        held;   // an accepted key is currently considered pressed
    bit [11:0] pend;   // key being qualified while not held (0 = none)
    int        age;    // matching cycles seen for pend after capture
    int        rel;    // consecutive cycles the held key was absent
    int        since;  // in-hold cycles counted towards the next repeat
    bit [11:0] code;
    bit [3:0]  idx;
    bit        valid;
  } model_t;

  model_t    m[2];
  bit [11:0] m_s1, m_s2;

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    for (int i = 0; i < 2; i++) begin
      m[i].held = 0; m[i].pend = '0; m[i].age = 0; m[i].rel = 0;
      m[i].since = 0; m[i].code = '0; m[i].idx = '0; m[i].valid = 0;
    end
  endtask

  task automatic model_step(input bit [11:0] x);
    bit [11:0] c;
    int rep;
    c = ($countones(m_s2) == 1) ? m_s2 : 12'h000;
    for (int i = 0; i < 2; i++) begin
      rep = (i == 0) ? 0 : R1;
      m[i].valid = 0;
      if (!m[i].held) begin
        if (m[i].pend == 0) begin
          if (c != 0) begin m[i].pend = c; m[i].age = 0; end
        end else if (c != m[i].pend) begin
          m[i].pend = 0;
        end else begin
          m[i].age++;
          if (m[i].age == D) begin
            m[i].held = 1; m[i].code = m[i].pend; m[i].idx = 4'($clog2(m[i].pend));
            m[i].valid = 1; m[i].since = 0; m[i].rel = 0; m[i].pend = 0;
          end
        end
      end else if (c == m[i].code) begin
        if (m[i].rel == 0 && rep != 0) begin
          m[i].since++;
          if (m[i].since == rep) begin m[i].valid = 1; m[i].since = 0; end
        end
        m[i].rel = 0;
      end else begin
        m[i].rel++;
        if (m[i].rel == D + 1) begin m[i].held = 0; m[i].pend = 0; end
      end
    end
    m_s2 = m_s1;
    m_s1 = x;
  endtask

  // One clock: advance the model alongside the DUTs, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step(keypad_in);
    #1;
    check("model_r0",  32'({valid0, held0, code0, idx0}),
          32'({m[0].valid, m[0].held, m[0].code, m[0].idx}));
    check("model_r10", 32'({valid1, held1, code1, idx1}),
          32'({m[1].valid, m[1].held, m[1].code, m[1].idx}));
    if (valid0) pulses0++;
    if (valid1) pulses1++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_code",  32'(code0),  32'(0));
    check("rst_idx",   32'(idx0),   32'(0));
    check("rst_valid", 32'(valid0), 32'(0));
    check("rst_held",  32'(held0),  32'(0));
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [11:0] kin;
    logic        valid;
    logic        held;
    logic [11:0] code;
    logic [3:0]  idx;
  } vec_t;

  function automatic vec_t mk(input logic [11:0] kin, input logic valid, input logic held,
                              input logic [11:0] code, input logic [3:0] idx);
    vec_t v;
    v.kin = kin; v.valid = valid; v.held = held; v.code = code; v.idx = idx;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    int first, fall, min_held, dur, r;
    int pos[$];
    bit [11:0] last_key;

    // Edge n of the table is the n-th clock after the key first appears.
    tbl[0]  = mk(12'h020, 0, 0, 12'h000, 4'd0);  // edge 1
    tbl[1]  = mk(12'h020, 0, 0, 12'h000, 4'd0);
    tbl[2]  = mk(12'h020, 0, 0, 12'h000, 4'd0);
    tbl[3]  = mk(12'h020, 0, 0, 12'h000, 4'd0);
    tbl[4]  = mk(12'h020, 0, 0, 12'h000, 4'd0);
    tbl[5]  = mk(12'h020, 0, 0, 12'h000, 4'd0);  // edge 6
    tbl[6]  = mk(12'h020, 1, 1, 12'h020, 4'd5);  // edge 7: accepted
    tbl[7]  = mk(12'h020, 0, 1, 12'h020, 4'd5);
    tbl[8]  = mk(12'h020, 0, 1, 12'h020, 4'd5);
    tbl[9]  = mk(12'h020, 0, 1, 12'h020, 4'd5);
    tbl[10] = mk(12'h020, 0, 1, 12'h020, 4'd5);
    tbl[11] = mk(12'h020, 0, 1, 12'h020, 4'd5);  // edge 12: last sample pressed
    tbl[12] = mk(12'h000, 0, 1, 12'h020, 4'd5);
    tbl[13] = mk(12'h000, 0, 1, 12'h020, 4'd5);
    tbl[14] = mk(12'h000, 0, 1, 12'h020, 4'd5);  // edge 15: candidate drops
    tbl[15] = mk(12'h000, 0, 1, 12'h020, 4'd5);
    tbl[16] = mk(12'h000, 0, 1, 12'h020, 4'd5);
    tbl[17] = mk(12'h000, 0, 1, 12'h020, 4'd5);
    tbl[18] = mk(12'h000, 0, 0, 12'h020, 4'd5);  // edge 19: release accepted
    tbl[19] = mk(12'h000, 0, 0, 12'h020, 4'd5);

    rst = 1'b1;
    keypad_in = '0;
    #2;
    apply_reset();

    // Basic press/release from the table.
    for (int i = 0; i < 20; i++) begin
      keypad_in = tbl[i].kin;
      tick();
      check($sformatf("tbl%0d_valid", i + 1), 32'(valid0), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_held",  i + 1), 32'(held0),  32'(tbl[i].held));
      check($sformatf("tbl%0d_code",  i + 1), 32'(code0),  32'(tbl[i].code));
      check($sformatf("tbl%0d_idx",   i + 1), 32'(idx0),   32'(tbl[i].idx));
    end

    // Bounce: high 2 / low 1, ten times, never accepted.
    apply_reset();
    pulses0 = 0;
    for (int n = 0; n < 10; n++) begin
      keypad_in = 12'h020; tick(); tick();
      keypad_in = 12'h000; tick();
    end
    repeat (6) tick();
    check("bounce_pulses", 32'(pulses0), 32'(0));
    check("bounce_held",   32'(held0),   32'(0));
    check("bounce_code",   32'(code0),   32'(0));

    // Chord is rejected; the remaining single key is a fresh press.
    keypad_in = 12'h003;
    repeat (30) tick();
    check("chord_pulses", 32'(pulses0), 32'(0));
    check("chord_code",   32'(code0),   32'(0));
    keypad_in = 12'h002;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (valid0) begin first = k; break; end
    end
    check("chord_then_single_latency", 32'(first), 32'(D + 3));
    check("chord_then_single_idx",     32'(idx0),  32'(1));
    keypad_in = 12'h000;
    repeat (12) tick();

    // Short drop-out keeps the key held; full release takes D+1 candidate cycles.
    keypad_in = 12'h800;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (valid0) begin first = k; break; end
    end
    check("drop_press_latency", 32'(first), 32'(D + 3));
    repeat (3) tick();
    pulses0 = 0;
    min_held = 1;
    for (int k = 0; k < 12; k++) begin
      keypad_in = (k < 2) ? 12'h000 : 12'h800;
      tick();
      if (!held0) min_held = 0;
    end
    check("drop_held", 32'(min_held), 32'(1));
    check("drop_no_pulse", 32'(pulses0), 32'(0));
    keypad_in = 12'h000;
    fall = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (!held0) begin fall = k; break; end
    end
    check("release_fall_tick", 32'(fall), 32'(2 + 1 + D));
    check("release_code_sticky", 32'(code0), 32'(12'h800));

    // Auto-repeat: three further pulses ten cycles apart within 35 held cycles.
    keypad_in = 12'h010;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (valid1) begin first = k; break; end
    end
    check("repeat_first_latency", 32'(first), 32'(D + 3));
    pulses0 = 0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (valid1) pos.push_back(k);
    end
    check("repeat_count", 32'(pos.size()), 32'(3));
    if (pos.size() >= 3) begin
      check("repeat_pos1", 32'(pos[0]), 32'(R1));
      check("repeat_pos2", 32'(pos[1]), 32'(2 * R1));
      check("repeat_pos3", 32'(pos[2]), 32'(3 * R1));
    end
    check("repeat_idx", 32'(idx1), 32'(4));
    check("norepeat_pulses", 32'(pulses0), 32'(0));

    // Reset while debouncing a press; key still held afterwards.
    keypad_in = 12'h000;
    repeat (10) tick();
    keypad_in = 12'h020;
    repeat (4) tick();
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_code",  32'(code0),  32'(0));
    check("midrst_idx",   32'(idx0),   32'(0));
    check("midrst_held",  32'(held0),  32'(0));
    check("midrst_code_r", 32'(code1), 32'(0));
    tick();
    rst = 1'b1;
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (valid0) begin first = k; break; end
    end
    check("midrst_latency", 32'(first), 32'(D + 3));

    // Random traffic against the model.
    last_key = 12'h001;
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        tick();
        rst = 1'b1;
      end else begin
        if (r < 5) begin
          keypad_in = 12'h000;
        end else if (r < 14) begin
          last_key = 12'(1) << $urandom_range(0, 11);
          keypad_in = last_key;
        end else if (r < 17) begin
          keypad_in = last_key | (12'(1) << $urandom_range(0, 11));
        end else begin
          keypad_in = last_key;
        end
        dur = (r >= 17) ? $urandom_range(1, 3) : $urandom_range(1, 14);
        repeat (dur) tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
